btb_update_queue: RTL and testbench



---
 rtl/btb_update_queue.sv | 110 +++++++++++
 tb/tb_btb_update_queue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_queue.sv
// Filters resolved taken branches that need a BTB write, buffers them in a
// circular FIFO and drains up to two per cycle without same-set collisions.
module btb_update_queue #(
  parameter int DEPTH    = 8,
  parameter int BTB_SIZE = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in1_valid,
  input  logic [63:0]              in1_pc,
  input  logic                     in1_taken,
  input  logic [63:0]              in1_target,
  input  logic                     in1_pred_valid,
  input  logic [63:0]              in1_pred_target,
  input  logic                     in2_valid,
  input  logic [63:0]              in2_pc,
  input  logic                     in2_taken,
  input  logic [63:0]              in2_target,
  input  logic                     in2_pred_valid,
  input  logic [63:0]              in2_pred_target,
  output logic                     in_ready,
  output logic [63:0]              pc_idx1,
  output logic [63:0]              target_pc1,
  output logic                     target_pc1_valid,
  output logic [63:0]              pc_idx2,
  output logic [63:0]              target_pc2,
  output logic                     target_pc2_valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int DATA_W = 64;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SET_W  = $clog2(BTB_SIZE);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

  logic [DATA_W-1:0] pc_q  [DEPTH];
  logic [DATA_W-1:0] tgt_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PTR_W-1:0]  head, tail, head_nx1, tail_wr2;
  logic              need1, need2, dup, en1, en2, deq1, deq2;
  logic [1:0]        enq_num, deq_num;
  logic [CNT_W-1:0]  count_next;

  function automatic logic [SET_W-1:0] set_of(input logic [DATA_W-1:0] pc);
    return pc[SET_W+1:2];
  endfunction

  function automatic logic needs_update(input logic v, input logic taken,
                                        input logic pred_v,
                                        input logic [DATA_W-1:0] target,
                                        input logic [DATA_W-1:0] pred_target);
    return v && taken && (!pred_v || (pred_target != target));
  endfunction

  // Enqueue side: filter, collapse same-PC pairs, all-or-nothing acceptance
  assign in_ready = (count <= READY_MAX);
  assign need1    = needs_update(in1_valid, in1_taken, in1_pred_valid, in1_target, in1_pred_target);
  assign need2    = needs_update(in2_valid, in2_taken, in2_pred_valid, in2_target, in2_pred_target);
  assign dup      = need1 && need2 && (in1_pc == in2_pc);
  assign en1      = in_ready && need1 && !dup;
  assign en2      = in_ready && need2;
  assign enq_num  = {1'b0, en1} + {1'b0, en2};
  assign tail_wr2 = tail + PTR_W'(en1);

  // Dequeue side: purely from registered state, second port blocked on set clash
  assign head_nx1 = head + PTR_W'(1);
  assign deq1     = (count != '0) && vld_q[head];
  assign deq2     = (count >= CNT_W'(2)) && vld_q[head_nx1] &&
                    (set_of(pc_q[head]) != set_of(pc_q[head_nx1]));
  assign deq_num  = {1'b0, deq1} + {1'b0, deq2};
  assign count_next = count + CNT_W'(enq_num) - CNT_W'(deq_num);

  assign target_pc1_valid = deq1;
  assign pc_idx1          = deq1 ? pc_q[head]      : '0;
  assign target_pc1       = deq1 ? tgt_q[head]     : '0;
  assign target_pc2_valid = deq2;
  assign pc_idx2          = deq2 ? pc_q[head_nx1]  : '0;
  assign target_pc2       = deq2 ? tgt_q[head_nx1] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld_q <= '0;
    end else begin
      assert (count_next <= FULL_CNT);
      head  <= head + PTR_W'(deq_num);
      tail  <= tail + PTR_W'(enq_num);
      count <= count_next;
      // Dequeue slots never alias the enqueue slots since two slots stay free
      if (deq1) vld_q[head]     <= 1'b0;
      if (deq2) vld_q[head_nx1] <= 1'b0;
      if (en1)  vld_q[tail]     <= 1'b1;
      if (en2)  vld_q[tail_wr2] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (en1) begin
      pc_q[tail]  <= in1_pc;
      tgt_q[tail] <= in1_target;
    end
    if (en2) begin
      pc_q[tail_wr2]  <= in2_pc;
      tgt_q[tail_wr2] <= in2_target;
    end
  end
endmodule

// File: tb/tb_btb_update_queue.sv
// Scoreboard bench for btb_update_queue: expected entries are queued when
// slots are accepted and compared as the update ports present them.
module tb_btb_update_queue;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] tgt;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in1_valid = 0, in1_taken = 0, in1_pred_valid = 0;
  logic [63:0] in1_pc = 0, in1_target = 0, in1_pred_target = 0;
  logic        in2_valid = 0, in2_taken = 0, in2_pred_valid = 0;
  logic [63:0] in2_pc = 0, in2_target = 0, in2_pred_target = 0;
  logic        in_ready, target_pc1_valid, target_pc2_valid;
  logic [63:0] pc_idx1, target_pc1, pc_idx2, target_pc2;
  logic [3:0]  count;

  int   tests = 0;
  int   failed = 0;
  bit   mon_en = 0;
  ent_t sb[$];
  bit   m_e1, m_e2;
  ent_t m_x1, m_x2;

  btb_update_queue #(.DEPTH(DEPTH), .BTB_SIZE(32)) dut (
    .clock(clock), .reset(reset),
    .in1_valid(in1_valid), .in1_pc(in1_pc), .in1_taken(in1_taken),
    .in1_target(in1_target), .in1_pred_valid(in1_pred_valid),
    .in1_pred_target(in1_pred_target),
    .in2_valid(in2_valid), .in2_pc(in2_pc), .in2_taken(in2_taken),
    .in2_target(in2_target), .in2_pred_valid(in2_pred_valid),
    .in2_pred_target(in2_pred_target),
    .in_ready(in_ready),
    .pc_idx1(pc_idx1), .target_pc1(target_pc1), .target_pc1_valid(target_pc1_valid),
    .pc_idx2(pc_idx2), .target_pc2(target_pc2), .target_pc2_valid(target_pc2_valid),
    .count(count)
  );

  always #5 clock = ~clock;

  function automatic bit tb_need(input logic v, input logic tk, input logic pv,
                                 input logic [63:0] tg, input logic [63:0] pt);
    if (!v || !tk) return 1'b0;
    if (!pv) return 1'b1;
    return pt != tg;
  endfunction

  // Scoreboard monitor: compares the update ports against the modelled queue
  always @(negedge clock) begin
    if (mon_en) begin
      #2;
      m_e1 = (sb.size() >= 1);
      m_e2 = 1'b0;
      m_x1 = '0;
      m_x2 = '0;
      if (m_e1) m_x1 = sb[0];
      if (sb.size() >= 2) begin
        m_e2 = (sb[0].pc[6:2] != sb[1].pc[6:2]);
        if (m_e2) m_x2 = sb[1];
      end
      tests++;
      if (count !== 4'(sb.size())) begin
        failed++; $display("FAIL sb_count got %0d exp %0d", count, sb.size());
      end
      tests++;
      if (in_ready !== (sb.size() <= DEPTH - 2)) begin
        failed++; $display("FAIL sb_in_ready got %b exp %b", in_ready, sb.size() <= DEPTH - 2);
      end
      tests++;
      if ({target_pc1_valid, target_pc2_valid} !== {m_e1, m_e2}) begin
        failed++; $display("FAIL sb_strobes got %b%b exp %b%b",
                           target_pc1_valid, target_pc2_valid, m_e1, m_e2);
      end
      tests++;
      if ({pc_idx1, target_pc1} !== {m_x1.pc, m_x1.tgt}) begin
        failed++; $display("FAIL sb_port1 got %h/%h exp %h/%h", pc_idx1, target_pc1, m_x1.pc, m_x1.tgt);
      end
      tests++;
      if ({pc_idx2, target_pc2} !== {m_x2.pc, m_x2.tgt}) begin
        failed++; $display("FAIL sb_port2 got %h/%h exp %h/%h", pc_idx2, target_pc2, m_x2.pc, m_x2.tgt);
      end
      if (m_e1) void'(sb.pop_front());
      if (m_e2) void'(sb.pop_front());
    end
  end

  task automatic set1(input logic v, input logic [63:0] pc, input logic tk,
                      input logic [63:0] tg, input logic pv, input logic [63:0] pt);
    in1_valid = v; in1_pc = pc; in1_taken = tk; in1_target = tg;
    in1_pred_valid = pv; in1_pred_target = pt;
  endtask

  task automatic set2(input logic v, input logic [63:0] pc, input logic tk,
                      input logic [63:0] tg, input logic pv, input logic [63:0] pt);
    in2_valid = v; in2_pc = pc; in2_taken = tk; in2_target = tg;
    in2_pred_valid = pv; in2_pred_target = pt;
  endtask

  task automatic clear_slots();
    set1(0, 0, 0, 0, 0, 0);
    set2(0, 0, 0, 0, 0, 0);
  endtask

  // One clock: predict acceptance from the model, push accepted entries
  task automatic tick();
    bit rdy, n1, n2, dp;
    rdy = (sb.size() <= DEPTH - 2);
    n1  = tb_need(in1_valid, in1_taken, in1_pred_valid, in1_target, in1_pred_target);
    n2  = tb_need(in2_valid, in2_taken, in2_pred_valid, in2_target, in2_pred_target);
    dp  = n1 && n2 && (in1_pc == in2_pc);
    @(posedge clock);
    if (reset) sb.delete();
    else if (rdy) begin
      if (n1 && !dp) sb.push_back('{pc: in1_pc, tgt: in1_target});
      if (n2)        sb.push_back('{pc: in2_pc, tgt: in2_target});
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    tests++; if (count !== 4'd0) begin failed++; $display("FAIL rst_count got %0d exp 0", count); end
    tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    tests++;
    if ({target_pc1_valid, target_pc2_valid} !== 2'b00) begin
      failed++; $display("FAIL rst_strobes got %b%b exp 00", target_pc1_valid, target_pc2_valid);
    end
    tests++;
    if ({pc_idx1, target_pc1, pc_idx2, target_pc2} !== 256'd0) begin
      failed++; $display("FAIL rst_data got %h %h %h %h exp 0", pc_idx1, target_pc1, pc_idx2, target_pc2);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_filter();
    set1(1, 64'h100, 1, 64'h200, 0, 64'h0);
    tick();
    clear_slots();
    tests++; if (count !== 4'd1) begin failed++; $display("FAIL filt_count got %0d exp 1", count); end
    tests++;
    if ({target_pc1_valid, target_pc2_valid, pc_idx1, target_pc1} !== {2'b10, 64'h100, 64'h200}) begin
      failed++; $display("FAIL filt_port1 got %b%b %h %h exp 10 100 200",
                         target_pc1_valid, target_pc2_valid, pc_idx1, target_pc1);
    end
    set1(1, 64'h104, 1, 64'h300, 1, 64'h300);
    tick();
    set1(1, 64'h108, 0, 64'h500, 0, 64'h0);
    tick();
    clear_slots();
    tests++; if (count !== 4'd0) begin failed++; $display("FAIL filt_none got %0d exp 0", count); end
  endtask

  task automatic test_dual_drain();
    set1(1, 64'h100, 1, 64'h200, 0, 64'h0);
    set2(1, 64'h104, 1, 64'h400, 1, 64'h999);
    tick();
    clear_slots();
    tests++;
    if ({target_pc1_valid, target_pc2_valid} !== 2'b11) begin
      failed++; $display("FAIL dual_strobes got %b%b exp 11", target_pc1_valid, target_pc2_valid);
    end
    tests++;
    if ({pc_idx1, target_pc1, pc_idx2, target_pc2} !== {64'h100, 64'h200, 64'h104, 64'h400}) begin
      failed++; $display("FAIL dual_data got %h %h %h %h exp 100 200 104 400",
                         pc_idx1, target_pc1, pc_idx2, target_pc2);
    end
    tick();
    tests++; if (count !== 4'd0) begin failed++; $display("FAIL dual_count got %0d exp 0", count); end
  endtask

  task automatic test_set_conflict();
    set1(1, 64'h100, 1, 64'h200, 0, 64'h0);
    set2(1, 64'h180, 1, 64'h500, 0, 64'h0);
    tick();
    clear_slots();
    tests++;
    if ({target_pc1_valid, target_pc2_valid, pc_idx1} !== {2'b10, 64'h100}) begin
      failed++; $display("FAIL conf_c1 got %b%b %h exp 10 100", target_pc1_valid, target_pc2_valid, pc_idx1);
    end
    tick();
    tests++;
    if ({target_pc1_valid, target_pc2_valid, pc_idx1, target_pc1} !== {2'b10, 64'h180, 64'h500}) begin
      failed++; $display("FAIL conf_c2 got %b%b %h %h exp 10 180 500",
                         target_pc1_valid, target_pc2_valid, pc_idx1, target_pc1);
    end
    tick();
  endtask

  task automatic test_back_pressure_wrap();
    int hits = 0;
    int accepted = 0;
    for (int n = 0; n < 24; n++) begin
      set1(1, 64'h2000 + 64'(n) * 64'h100, 1, 64'h8000 + 64'(n), 0, 64'h0);
      set2(1, 64'h2080 + 64'(n) * 64'h100, 1, 64'h9000 + 64'(n), 0, 64'h0);
      if (sb.size() == DEPTH - 1) begin
        hits++;
        tests++;
        if ({in_ready, count} !== {1'b0, 4'd7}) begin
          failed++; $display("FAIL bp_full got ready=%b count=%0d exp ready=0 count=7", in_ready, count);
        end
      end
      if (sb.size() <= DEPTH - 2) accepted += 2;
      tick();
    end
    clear_slots();
    tests++;
    if (hits == 0 || accepted <= 2 * DEPTH) begin
      failed++; $display("FAIL bp_coverage got hits=%0d accepted=%0d exp hits>0 accepted>%0d",
                         hits, accepted, 2 * DEPTH);
    end
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    tests++; if (count !== 4'd0) begin failed++; $display("FAIL bp_drain got %0d exp 0", count); end
  endtask

  task automatic test_duplicate();
    set1(1, 64'h140, 1, 64'h600, 0, 64'h0);
    set2(1, 64'h140, 1, 64'h700, 0, 64'h0);
    tick();
    clear_slots();
    tests++; if (count !== 4'd1) begin failed++; $display("FAIL dup_count got %0d exp 1", count); end
    tests++;
    if ({pc_idx1, target_pc1} !== {64'h140, 64'h700}) begin
      failed++; $display("FAIL dup_port1 got %h %h exp 140 700", pc_idx1, target_pc1);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 4; n++) begin
      set1(1, 64'h3000 + 64'(n) * 64'h100, 1, 64'hA000 + 64'(n), 0, 64'h0);
      set2(1, 64'h3080 + 64'(n) * 64'h100, 1, 64'hB000 + 64'(n), 0, 64'h0);
      tick();
    end
    tests++; if (count !== 4'd5) begin failed++; $display("FAIL midrst_pre got %0d exp 5", count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_slots();
    tests++;
    if ({count, target_pc1_valid, target_pc2_valid} !== {4'd0, 2'b00}) begin
      failed++; $display("FAIL midrst_post got count=%0d strobes=%b%b exp 0 00",
                         count, target_pc1_valid, target_pc2_valid);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_filter();
    test_dual_drain();
    test_set_conflict();
    test_duplicate();
    test_back_pressure_wrap();
    test_reset_mid();
    repeat (3) tick();
    tests++;
    if (sb.size() != 0) begin failed++; $display("FAIL final_empty got %0d exp 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
